// File: rtl/voice_playback_scheduler_if.sv
// rtl/voice_playback_scheduler_if.sv - sample RAM port and Audio_Controller handshake bundle
interface voice_playback_scheduler_if #(
    parameter int ADDR_W   = 14,
    parameter int SAMPLE_W = 6
);
    logic [ADDR_W-1:0]   ram_addr;
    logic [SAMPLE_W-1:0] ram_q;
    logic                audio_out_allowed;
    logic                write_audio_out;
    logic [31:0]         left_channel_audio_out;
    logic [31:0]         right_channel_audio_out;

    modport master (
        output ram_addr,
        input  ram_q,
        input  audio_out_allowed,
        output write_audio_out,
        output left_channel_audio_out,
        output right_channel_audio_out
    );

    modport slave (
        input  ram_addr,
        output ram_q,
        output audio_out_allowed,
        input  write_audio_out,
        input  left_channel_audio_out,
        input  right_channel_audio_out
    );
endinterface

// File: rtl/voice_playback_scheduler.sv
// rtl/voice_playback_scheduler.sv - per-tick voice scheduler sharing one sample RAM, mixing voices into one output sample
module voice_playback_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 14,
    parameter int SAMPLE_W   = 6,
    parameter int RD_LAT     = 2,
    parameter int TICK_DIV   = 1200
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_VOICES-1:0]      voice_en,
    voice_playback_scheduler_if.master bus,
    output logic                       busy,
    output logic [7:0]                 drop_count
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int OFS_W  = ADDR_W - VIDX_W;
    localparam int ACC_W  = SAMPLE_W + VIDX_W;
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;
    state_t state, state_n;

    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [VIDX_W-1:0] vidx;
    logic [OFS_W-1:0]  offset [NUM_VOICES];

    logic              tag_v   [RD_LAT];
    logic              tag_en  [RD_LAT];
    logic [VIDX_W-1:0] tag_idx [RD_LAT];

    logic [ACC_W-1:0]  acc, acc_sum, chan, sample_ext;
    logic              start_frame, issue, latch, drop, do_write, last_emerge;

    assign tick        = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign sample_ext  = {{VIDX_W{bus.ram_q[SAMPLE_W-1]}}, bus.ram_q};
    assign acc_sum     = acc + ((tag_v[RD_LAT-1] && tag_en[RD_LAT-1]) ? sample_ext : '0);
    // The frame is complete once the last voice's read comes out of the delay line.
    assign last_emerge = tag_v[RD_LAT-1] && (tag_idx[RD_LAT-1] == LAST_V);

    assign bus.ram_addr                = issue ? {vidx, offset[vidx]} : '0;
    assign bus.write_audio_out         = do_write;
    assign bus.left_channel_audio_out  = {chan, {(32 - ACC_W){1'b0}}};
    assign bus.right_channel_audio_out = {chan, {(32 - ACC_W){1'b0}}};
    assign busy                        = (state != S_IDLE);

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        issue       = 1'b0;
        latch       = 1'b0;
        drop        = 1'b0;
        do_write    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    start_frame = 1'b1;
                    state_n     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue = 1'b1;
                if (vidx == LAST_V) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_emerge) begin
                    latch   = 1'b1;
                    state_n = S_OUT;
                end
            end
            S_OUT: begin
                // A tick here means the sample was never accepted: discard it and restart.
                if (tick) begin
                    drop        = 1'b1;
                    start_frame = 1'b1;
                    state_n     = S_ISSUE;
                end else if (bus.audio_out_allowed) begin
                    do_write = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            vidx       <= '0;
            acc        <= '0;
            chan       <= '0;
            drop_count <= '0;
            for (int v = 0; v < NUM_VOICES; v++) offset[v] <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_v[s]   <= 1'b0;
                tag_en[s]  <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            state    <= state_n;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);

            if (start_frame)  vidx <= '0;
            else if (issue)   vidx <= vidx + VIDX_W'(1);

            // Disabled voices rewind so the next enable retriggers the note from its start.
            if (issue) offset[vidx] <= voice_en[vidx] ? offset[vidx] + OFS_W'(1) : '0;

            tag_v[0]   <= issue;
            tag_en[0]  <= voice_en[vidx];
            tag_idx[0] <= vidx;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_v[s]   <= tag_v[s-1];
                tag_en[s]  <= tag_en[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end

            acc <= start_frame ? '0 : acc_sum;
            if (latch) chan <= acc_sum;

            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_voice_playback_scheduler.sv
// tb/tb_voice_playback_scheduler.sv - scoreboard bench for voice_playback_scheduler
module tb_voice_playback_scheduler;
    localparam int NV = 4;
    localparam int AW = 14;
    localparam int SW = 6;
    localparam int RL = 2;
    localparam int TD = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] voice_en = '0;
    logic          allowed = 1'b1;
    logic          busy;
    logic [7:0]    drop_count;

    voice_playback_scheduler_if #(.ADDR_W(AW), .SAMPLE_W(SW)) bus ();

    voice_playback_scheduler #(
        .NUM_VOICES(NV), .ADDR_W(AW), .SAMPLE_W(SW), .RD_LAT(RL), .TICK_DIV(TD)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .voice_en  (voice_en),
        .bus       (bus),
        .busy      (busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Sample RAM: region 1 holds addr[5:0], everything else reads 0; two-cycle latency.
    logic [SW-1:0] rd1 = '0, rd2 = '0;
    always @(posedge clk) begin
        rd1 <= (bus.ram_addr[AW-1:AW-2] == 2'd1) ? bus.ram_addr[5:0] : '0;
        rd2 <= rd1;
    end
    assign bus.ram_q             = rd2;
    assign bus.audio_out_allowed = allowed;

    int k;
    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_smp  [$];
    logic [11:0]   off [NV];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_extra(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
    endtask

    function automatic logic [SW-1:0] ram_model(input logic [AW-1:0] a);
        return (a[AW-1:AW-2] == 2'd1) ? a[5:0] : '0;
    endfunction

    task automatic push_frame(input logic [NV-1:0] en, input bit will_write);
        logic [7:0]    acc;
        logic [AW-1:0] a;
        logic [SW-1:0] d;
        voice_en = en;
        acc = '0;
        for (int v = 0; v < NV; v++) begin
            a = (AW'(v) << 12) | AW'(off[v]);
            exp_addr.push_back(a);
            if (en[v]) begin
                d = ram_model(a);
                acc = acc + {{2{d[SW-1]}}, d};
                off[v] = off[v] + 12'd1;
            end else begin
                off[v] = '0;
            end
        end
        if (will_write) exp_smp.push_back({acc, 24'h0});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !done) begin
            if (k >= TD && (k % TD) < NV) begin
                if (exp_addr.size() == 0) fail_extra("addr_extra", 32'(bus.ram_addr));
                else check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.write_audio_out) begin
                if (exp_smp.size() == 0) begin
                    fail_extra("write_extra", bus.left_channel_audio_out);
                end else begin
                    check("right", bus.right_channel_audio_out, exp_smp[0]);
                    check("left", bus.left_channel_audio_out, exp_smp.pop_front());
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},  32'(bus.ram_addr), 32'h0);
        check({tag, "_write"}, 32'(bus.write_audio_out), 32'h0);
        check({tag, "_left"},  bus.left_channel_audio_out, 32'h0);
        check({tag, "_right"}, bus.right_channel_audio_out, 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_drop"},  32'(drop_count), 32'h0);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) off[v] = '0;
        rst = 1'b1;
        wait_cycles(3);
        check_reset_state("reset");
        rst = 1'b0;
        wait_cycles(10);

        for (int n = 0; n < 3; n++) begin
            push_frame(4'b0000, 1'b1);
            wait_cycles(TD);
        end

        // Voice 1 sweeps its whole region and wraps back to 0x1000.
        for (int n = 0; n < 4098; n++) begin
            push_frame(4'b0010, 1'b1);
            wait_cycles(TD);
        end

        push_frame(4'b0000, 1'b1);
        wait_cycles(TD);
        push_frame(4'b0010, 1'b1);
        wait_cycles(TD);
        push_frame(4'b0010, 1'b1);
        wait_cycles(TD);

        allowed = 1'b0;
        for (int n = 0; n < 3; n++) begin
            push_frame(4'b0010, 1'b0);
            wait_cycles(TD);
        end
        push_frame(4'b0010, 1'b1);
        wait_cycles(TD);
        check("drop_count_held", 32'(drop_count), 32'd3);
        check("no_write_held", 32'(bus.write_audio_out), 32'h0);
        check("busy_in_out", 32'(busy), 32'h1);
        allowed = 1'b1;
        @(negedge clk);
        check("write_on_allow", 32'(bus.write_audio_out), 32'h1);
        push_frame(4'b0010, 1'b1);
        wait_cycles(1);
        check("drop_count_after", 32'(drop_count), 32'd3);
        check("busy_after_write", 32'(busy), 32'h0);
        wait_cycles(TD - 1);

        push_frame(4'b0010, 1'b1);
        wait_cycles(12);
        rst = 1'b1;
        exp_addr.delete();
        exp_smp.delete();
        for (int v = 0; v < NV; v++) off[v] = '0;
        #1;
        check_reset_state("midreset");
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(10);

        push_frame(4'b0010, 1'b1);
        wait_cycles(TD);
        push_frame(4'b1111, 1'b1);
        wait_cycles(TD);
        push_frame(4'b1111, 1'b1);
        wait_cycles(TD);
        push_frame(4'b0010, 1'b1);
        wait_cycles(TD);

        done = 1'b1;
        check("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
        check("smp_queue_empty", 32'(exp_smp.size()), 32'h0);
        check("drop_count_final", 32'(drop_count), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #960000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got still running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/voice_playback_scheduler.md
Name: voice_playback_scheduler

Overview:
- Per-sample-tick scheduler that time-shares the single-port sample RAM (the 16K x 6 note-sample memory) between NUM_VOICES note voices.
- Issues one RAM read per voice, then sums the returned signed samples into one mix.
- Hands the mix to Audio_Controller through its write_audio_out / audio_out_allowed handshake.
- Replaces the free-running address counter in the top level; keys or switches drive voice_en.

Parameters:
- NUM_VOICES, 4: voices; power of two, 2..8.
- ADDR_W, 14: RAM address width. Each voice owns region v*2^(ADDR_W-log2(NUM_VOICES)), so the default region is 4096 words.
- SAMPLE_W, 6: RAM data width; signed two's complement.
- RD_LAT, 2: RAM read latency in clocks, from address registered to q valid.
- TICK_DIV, 1200: CLOCK_50 cycles per output sample. Must satisfy TICK_DIV >= NUM_VOICES+RD_LAT+4.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- voice_en  in  NUM_VOICES  level; bit v high means voice v plays.
- ram_addr  out  ADDR_W  address to the sample RAM.
- ram_q  in  SAMPLE_W  RAM read data.
- audio_out_allowed  in  1  from Audio_Controller; output FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller.
- left_channel_audio_out  out  32  mixed sample, MSB-aligned.
- right_channel_audio_out  out  32  identical to left.
- busy  out  1  high while a frame is in progress (not IDLE).
- drop_count  out  8  saturating count of frames lost.

Behaviour:
- Reset, asynchronous: all outputs 0; tick counter 0; all voice offsets 0; accumulator 0; FSM in IDLE.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick = (count == TICK_DIV-1), one cycle per period.
- FSM: IDLE -> ISSUE -> DRAIN -> OUT -> IDLE.
- IDLE: on tick, clear accumulator, set voice index i=0, go to ISSUE.
- ISSUE, one cycle per voice, i = 0..NUM_VOICES-1:
  - ram_addr = {i, offset[i]}.
  - Tag the read with i and with voice_en[i] sampled in that cycle.
  - Offset update in the same cycle: if voice_en[i], offset[i] = offset[i]+1, wrapping from region_size-1 to 0 (stays inside the region); else offset[i] = 0 (retrigger from note start).
  - After the last voice, go to DRAIN.
- Read pipeline: tag shifts through an RD_LAT-deep delay line.
  - When a tag emerges and its enable bit is 1, add sign-extended ram_q to the accumulator.
  - Disabled voices contribute 0.
  - Accumulator width is SAMPLE_W+log2(NUM_VOICES); no overflow is possible.
- DRAIN: wait until the delay line is empty, i.e. RD_LAT cycles after the last issue. Then latch the accumulator onto both channel outputs, go to OUT.
- Output format: channel = {acc, zeros}, acc in the MSBs, padded to 32 bits. Full scale matches the previous {sample,26'b0} convention scaled by 1/NUM_VOICES headroom.
- OUT:
  - In any cycle with audio_out_allowed=1, assert write_audio_out for exactly that one cycle, then go to IDLE.
  - Channel outputs hold until the next latch.
- Tick while not IDLE: only OUT can see this under the TICK_DIV constraint.
  - The pending sample is discarded and no write is issued.
  - drop_count increments, saturating at 255.
  - FSM goes straight to ISSUE with a new frame; this counts as that tick's IDLE transition.
- First frame: ram_addr is 0 while not issuing.
- Frame length: fixed at NUM_VOICES+RD_LAT+1 cycles from tick to entering OUT, independent of voice_en.
- voice_en changing mid-frame: takes effect only for voices not yet issued in that frame.
- Reset mid-frame: immediate return to reset state. No partial write.

Test Plan:
Bench settings: TICK_DIV=20, RD_LAT=2, NUM_VOICES=4. RAM model returns addr[5:0] for addresses in region 1 and 0 elsewhere, with 2-cycle latency.
- Reset released, voice_en=0, audio_out_allowed=1 -> a write every 20 clocks with left=right=0. ram_addr sequence per frame is 0x0000, 0x1000, 0x2000, 0x3000. drop_count=0.
- voice_en=4'b0010, voice 1 region data 0..63 -> frame n outputs acc=n mod 64 sign-extended. Frame 32 outputs -32, so left = 0xE0000000 with acc 8 bits in MSBs.
- Voice 1 offset reaches 0xFFF -> next frame reads 0x1000 again; address never reaches 0x2000 from voice 1.
- Hold audio_out_allowed=0 for 3 tick periods -> no write_audio_out and drop_count=3. Raise it -> a write within 1 cycle; count holds at 3.
- Drop voice_en[1] for one frame, then reassert -> that frame's contribution is 0; next frame reads 0x1000, i.e. a note retrigger.
- Assert reset for 1 cycle during ISSUE of voice 2 -> outputs 0 immediately; no write until the first frame after restart; all offsets back to 0.
